// File: rtl/float_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float_pkg
// Description : Shared IEEE-754 single-precision constants and the output
//               record type for the fraction/float converters.
// Revision    : 1.0 - initial release
// ============================================================================
package float_pkg;

    localparam int EXP_BIAS   = 127;
    localparam int IEEE_EXP_W = 8;
    localparam int IEEE_MAN_W = 23;

    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    typedef struct packed {
        logic [31:0] data;
        logic        ovf;
        logic        unf;
        logic        inexact;
    } out_word_t;

endpackage

`default_nettype wire

// File: rtl/lzc.sv
`default_nettype none
// ============================================================================
// Module      : lzc
// Description : Combinational leading-one locator: index of the most
//               significant set bit plus an all-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module lzc #(
    parameter int WIDTH = 24,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [POS_W-1:0] o_pos,
    output logic             o_zero
);

    // Later iterations override earlier ones, so the highest set bit wins.
    always_comb begin
        o_pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) begin
                o_pos = i[POS_W-1:0];
            end
        end
    end

    assign o_zero = ~|i_vec;

endmodule

`default_nettype wire

// File: rtl/frac_to_ieee754.sv
`default_nettype none
// ============================================================================
// Module      : frac_to_ieee754
// Description : Three-stage pipelined exponent+fraction to IEEE-754 single
//               converter with round-to-nearest-even and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module frac_to_ieee754
    import float_pkg::*;
#(
    parameter int WORD_LENGTH = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WORD_LENGTH+7:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [31:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_ovf,
    output logic                   out_unf,
    output logic                   out_inexact
);

    localparam int c_pos_w = $clog2(WORD_LENGTH);
    localparam int c_ext_w = WORD_LENGTH + IEEE_MAN_W;
    localparam logic [c_pos_w-1:0]  c_top_idx  = c_pos_w'(WORD_LENGTH - 1);
    localparam logic signed [10:0]  c_frac_msb = 11'(WORD_LENGTH - 1);

    typedef struct packed {
        logic                   valid;
        logic                   sign;
        logic [WORD_LENGTH-1:0] mag;
        logic [IEEE_EXP_W-1:0]  exp;
    } st1_t;

    typedef struct packed {
        logic                   valid;
        logic                   sign;
        logic                   zero;
        logic [WORD_LENGTH-2:0] frac;
        logic signed [10:0]     exp;
    } st2_t;

    st1_t      st1_q, st1_d;
    st2_t      st2_q, st2_d;
    out_word_t out_q, out_d;
    logic      out_valid_q, out_valid_d;

    logic                     w_en;
    logic [WORD_LENGTH-1:0]   w_m;
    logic [c_pos_w-1:0]       w_pos;
    logic                     w_zero;
    logic [c_pos_w-1:0]       w_shift;
    logic signed [10:0]       w_exp2;
    logic [c_ext_w-1:0]       w_ext;
    logic [IEEE_MAN_W-1:0]    w_mant;
    logic                     w_guard;
    logic                     w_sticky;
    logic                     w_round_up;
    logic [IEEE_MAN_W:0]      w_mant_r;
    logic signed [10:0]       w_exp3;

    assign w_en     = !out_valid_q || out_ready;
    assign in_ready = w_en;
    assign w_m      = in_data[WORD_LENGTH-1:0];

    // Stage 1: sign/magnitude split; the most negative code maps to 2^(W-1).
    always_comb begin
        st1_d = st1_q;
        if (w_en) begin
            st1_d.valid = in_valid;
            st1_d.sign  = w_m[WORD_LENGTH-1];
            st1_d.mag   = w_m[WORD_LENGTH-1] ? (~w_m + WORD_LENGTH'(1)) : w_m;
            st1_d.exp   = in_data[WORD_LENGTH+7:WORD_LENGTH];
        end
    end

    lzc #(
        .WIDTH (WORD_LENGTH),
        .POS_W (c_pos_w)
    ) u_lzc (
        .i_vec  (st1_q.mag),
        .o_pos  (w_pos),
        .o_zero (w_zero)
    );

    // Stage 2: the leading one is shifted out, keeping only the bits below it.
    assign w_shift = c_top_idx - w_pos;
    assign w_exp2  = $signed({3'b000, st1_q.exp}) - c_frac_msb
                   + $signed({{(11 - c_pos_w){1'b0}}, w_pos});

    always_comb begin
        st2_d = st2_q;
        if (w_en) begin
            st2_d.valid = st1_q.valid;
            st2_d.sign  = st1_q.sign;
            st2_d.zero  = w_zero;
            st2_d.frac  = st1_q.mag[WORD_LENGTH-2:0] << w_shift;
            st2_d.exp   = w_exp2;
        end
    end

    // Stage 3: zero padding makes narrow fractions exact (guard/sticky = 0).
    assign w_ext      = {st2_q.frac, {(IEEE_MAN_W + 1){1'b0}}};
    assign w_mant     = w_ext[c_ext_w-1 -: IEEE_MAN_W];
    assign w_guard    = w_ext[c_ext_w-1-IEEE_MAN_W];
    assign w_sticky   = |w_ext[c_ext_w-2-IEEE_MAN_W:0];
    assign w_round_up = w_guard && (w_sticky || w_mant[0]);
    assign w_mant_r   = {1'b0, w_mant} + {{IEEE_MAN_W{1'b0}}, w_round_up};
    assign w_exp3     = st2_q.exp + (w_mant_r[IEEE_MAN_W] ? 11'sd1 : 11'sd0);

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (w_en) begin
            out_valid_d   = st2_q.valid;
            out_d.ovf     = 1'b0;
            out_d.unf     = 1'b0;
            out_d.inexact = 1'b0;
            if (st2_q.zero) begin
                out_d.data = 32'h0000_0000;
            end else if (w_exp3 >= 11'sd255) begin
                out_d.data    = st2_q.sign ? NEG_INF : POS_INF;
                out_d.ovf     = 1'b1;
                out_d.inexact = 1'b1;
            end else if (w_exp3 <= 11'sd0) begin
                out_d.data    = {st2_q.sign, 31'b0};
                out_d.unf     = 1'b1;
                out_d.inexact = 1'b1;
            end else begin
                out_d.data    = {st2_q.sign, w_exp3[IEEE_EXP_W-1:0],
                                 w_mant_r[IEEE_MAN_W-1:0]};
                out_d.inexact = w_guard || w_sticky;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st1_q       <= '0;
            st2_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            st1_q       <= st1_d;
            st2_q       <= st2_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data    = out_q.data;
    assign out_ovf     = out_q.ovf;
    assign out_unf     = out_q.unf;
    assign out_inexact = out_q.inexact;
    assign out_valid   = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_frac_to_ieee754.sv
`default_nettype none
// ============================================================================
// Module      : tb_frac_to_ieee754
// Description : Scoreboard bench for frac_to_ieee754 at W=24 and W=32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frac_to_ieee754;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] a_data;
    logic        a_valid, a_ready, a_ovalid, a_oready, a_ovf, a_unf, a_inx;
    logic [31:0] a_out;
    logic [39:0] b_data;
    logic        b_valid, b_ready, b_ovalid, b_oready, b_ovf, b_unf, b_inx;
    logic [31:0] b_out;

    frac_to_ieee754 #(.WORD_LENGTH(24)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .out_data(a_out), .out_valid(a_ovalid),
        .out_ready(a_oready), .out_ovf(a_ovf), .out_unf(a_unf),
        .out_inexact(a_inx)
    );

    frac_to_ieee754 #(.WORD_LENGTH(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .out_data(b_out), .out_valid(b_ovalid),
        .out_ready(b_oready), .out_ovf(b_ovf), .out_unf(b_unf),
        .out_inexact(b_inx)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        ovf;
        logic        unf;
        logic        inx;
        logic        lat;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb_a[$];
    exp_t        sb_b[$];
    exp_t        ea, eb;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitors: compare the head of each scoreboard whenever a word is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_ovalid && !a_oready) check("a_in_ready_stall", {63'b0, a_ready}, 64'd0);
            if (a_ovalid) begin
                if (sb_a.size() == 0) begin
                    check("a_spurious_word", {32'b0, a_out}, 64'hDEAD);
                end else begin
                    ea = sb_a[0];
                    check("a_word", {29'b0, a_out, a_ovf, a_unf, a_inx},
                          {29'b0, ea.data, ea.ovf, ea.unf, ea.inx});
                    if (ea.lat) check("a_latency", {32'b0, cyc - ea.cyc}, 64'd3);
                    if (a_oready) void'(sb_a.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_ovalid) begin
            if (sb_b.size() == 0) begin
                check("b_spurious_word", {32'b0, b_out}, 64'hDEAD);
            end else begin
                eb = sb_b[0];
                check("b_word", {29'b0, b_out, b_ovf, b_unf, b_inx},
                      {29'b0, eb.data, eb.ovf, eb.unf, eb.inx});
                if (eb.lat) check("b_latency", {32'b0, cyc - eb.cyc}, 64'd3);
                if (b_oready) void'(sb_b.pop_front());
            end
        end
    end

    // fl = {ovf, unf, inexact}; lat requests a latency check (isolated words only).
    task automatic send_a(input logic [7:0] e, input logic [23:0] m, input logic [31:0] d,
                          input logic [2:0] fl, input logic lat);
        int   n;
        exp_t x;
        a_data  = {e, m};
        a_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (!a_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!a_ready) begin
            check("a_send_timeout", 64'd0, 64'd1);
        end else begin
            x.data = d;
            {x.ovf, x.unf, x.inx} = fl;
            x.lat = lat;
            x.cyc = cyc;
            sb_a.push_back(x);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic send_b(input logic [7:0] e, input logic [31:0] m, input logic [31:0] d,
                          input logic [2:0] fl);
        int   n;
        exp_t x;
        b_data  = {e, m};
        b_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (!b_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!b_ready) begin
            check("b_send_timeout", 64'd0, 64'd1);
        end else begin
            x.data = d;
            {x.ovf, x.unf, x.inx} = fl;
            x.lat = 1'b1;
            x.cyc = cyc;
            sb_b.push_back(x);
        end
        @(posedge clk);
        #2;
        b_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
    endtask

    task automatic idle_a(input int k);
        a_valid = 1'b0;
        repeat (k) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        a_data = '0; b_data = '0; a_oready = 1'b1; b_oready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", {63'b0, a_ovalid}, 64'd0);
        check("rst_out_data",  {32'b0, a_out}, 64'd0);
        check("rst_flags",     {61'b0, a_ovf, a_unf, a_inx}, 64'd0);
        check("rst_in_ready",  {63'b0, a_ready}, 64'd1);
        check("rst_b_valid",   {63'b0, b_ovalid}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Basic values, most negative fraction, zero, leading-one search
        send_a(8'd128, 24'h400000, 32'h3F80_0000, 3'b000, 1'b1); idle_a(5);
        send_a(8'd129, 24'hC00000, 32'hC000_0000, 3'b000, 1'b1); idle_a(5);
        send_a(8'd127, 24'h800000, 32'hBF80_0000, 3'b000, 1'b1); idle_a(5);
        send_a(8'd77,  24'h000000, 32'h0000_0000, 3'b000, 1'b1); idle_a(5);
        send_a(8'd150, 24'h000001, 32'h3F80_0000, 3'b000, 1'b1); idle_a(5);
        send_a(8'd150, 24'hFFFFFF, 32'hBF80_0000, 3'b000, 1'b1); idle_a(5);
        send_a(8'd255, 24'h7FFFFF, 32'h7F7F_FFFE, 3'b000, 1'b1); idle_a(5);

        // Overflow / underflow boundaries
        send_a(8'd255, 24'h800000, 32'hFF80_0000, 3'b101, 1'b1); idle_a(5);
        send_a(8'd255, 24'h400000, 32'h7F00_0000, 3'b000, 1'b1); idle_a(5);
        send_a(8'd0,   24'h400000, 32'h0000_0000, 3'b011, 1'b1); idle_a(5);
        send_a(8'd0,   24'hC00000, 32'h8000_0000, 3'b011, 1'b1); idle_a(5);
        send_a(8'd1,   24'h400000, 32'h0000_0000, 3'b011, 1'b1); idle_a(5);
        send_a(8'd2,   24'h400000, 32'h0080_0000, 3'b000, 1'b1); idle_a(5);

        // Rounding at W=32
        send_b(8'd127, 32'h7FFFFFFF, 32'h3F80_0000, 3'b001);
        send_b(8'd128, 32'h40000040, 32'h3F80_0000, 3'b001);
        send_b(8'd128, 32'h400000C0, 32'h3F80_0002, 3'b001);
        send_b(8'd128, 32'h40000080, 32'h3F80_0001, 3'b000);
        send_b(8'd128, 32'h40000041, 32'h3F80_0001, 3'b001);
        send_b(8'd255, 32'h7FFFFFFF, 32'h7F80_0000, 3'b101);
        send_b(8'd1,   32'h7FFFFFFF, 32'h0080_0000, 3'b001);

        // Back-to-back stream with a downstream stall
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    send_a(8'(128 + k), k[0] ? 24'hC00000 : 24'h400000,
                           {k[0], 8'(127 + k), 23'b0}, 3'b000, 1'b0);
                end
                a_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #2 a_oready = 1'b0;
                repeat (4) @(posedge clk);
                #2 a_oready = 1'b1;
            end
        join
        idle_a(15);
        check("a_stream_drained", {32'b0, 32'(sb_a.size())}, 64'd0);

        // Reset with words in flight
        send_a(8'd130, 24'h400000, 32'h4080_0000, 3'b000, 1'b0);
        send_a(8'd130, 24'hC00000, 32'hC080_0000, 3'b000, 1'b0);
        send_a(8'd130, 24'h400000, 32'h4080_0000, 3'b000, 1'b0);
        a_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("midrst_out_valid", {63'b0, a_ovalid}, 64'd0);
        check("midrst_out_data",  {32'b0, a_out}, 64'd0);
        check("midrst_flags",     {61'b0, a_ovf, a_unf, a_inx}, 64'd0);
        sb_a.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;
        send_a(8'd131, 24'hC00000, 32'hC100_0000, 3'b000, 1'b1); idle_a(8);

        check("a_final_drained", {32'b0, 32'(sb_a.size())}, 64'd0);
        check("b_final_drained", {32'b0, 32'(sb_b.size())}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
